// File: rtl/traffic_pkg.sv
// Shared types and sizing helpers for the traffic light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  localparam int unsigned DEF_RED_CYCLES        = 10;
  localparam int unsigned DEF_GREEN_CYCLES      = 15;
  localparam int unsigned DEF_YELLOW_CYCLES     = 5;
  localparam int unsigned DEF_GREEN_MIN_CYCLES  = 5;
  localparam int unsigned DEF_FLASH_HALF_CYCLES = 4;

  function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counter only ever holds duration-1, so $clog2(duration) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned dur);
    return (dur < 2) ? 1 : $clog2(dur);
  endfunction

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// Loadable down-counter; done flags an enabled cycle at count zero.
module phase_timer #(
  parameter int unsigned            WIDTH     = 4,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = en && (count == '0);

endmodule

// File: rtl/traffic_light_controller.sv
// Single-approach RED/GREEN/YELLOW sequencer with pedestrian early exit,
// walk indication and fault flash mode.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int unsigned RED_CYCLES        = DEF_RED_CYCLES,
  parameter int unsigned GREEN_CYCLES      = DEF_GREEN_CYCLES,
  parameter int unsigned YELLOW_CYCLES     = DEF_YELLOW_CYCLES,
  parameter int unsigned GREEN_MIN_CYCLES  = DEF_GREEN_MIN_CYCLES,
  parameter int unsigned FLASH_HALF_CYCLES = DEF_FLASH_HALF_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       fault,
  output logic       RED,
  output logic       GREEN,
  output logic       YELLOW,
  output logic       walk,
  output logic [1:0] phase
);

  localparam int unsigned CW = cnt_width(max_dur(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES));
  localparam int unsigned FW = cnt_width(FLASH_HALF_CYCLES);

  localparam logic [CW-1:0] RED_LOAD    = CW'(RED_CYCLES - 1);
  localparam logic [CW-1:0] GREEN_LOAD  = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] YELLOW_LOAD = CW'(YELLOW_CYCLES - 1);
  // GREEN has been lit for >= GREEN_MIN_CYCLES once count drops to this value.
  localparam logic [CW-1:0] GREEN_EXIT  = CW'(GREEN_CYCLES - GREEN_MIN_CYCLES);
  localparam logic [FW-1:0] FLASH_LOAD  = FW'(FLASH_HALF_CYCLES - 1);

  phase_e          state, state_nxt;
  logic            ped_pending, ped_nxt;
  logic            walk_nxt;
  logic            flash_on, flash_nxt;

  logic            tmr_load, tmr_en, tmr_done;
  logic [CW-1:0]   tmr_val, count;
  logic            fl_load, fl_en, fl_done;
  logic [FW-1:0]   fl_count_unused;

  phase_timer #(.WIDTH(CW), .RESET_VAL(RED_LOAD)) u_phase_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .count    (count),
    .done     (tmr_done)
  );

  phase_timer #(.WIDTH(FW), .RESET_VAL(FLASH_LOAD)) u_flash_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (fl_load),
    .en       (fl_en),
    .load_val (FLASH_LOAD),
    .count    (fl_count_unused),
    .done     (fl_done)
  );

  always_comb begin
    state_nxt = state;
    ped_nxt   = ped_pending | ped_req;
    walk_nxt  = walk;
    flash_nxt = flash_on;
    tmr_load  = 1'b0;
    tmr_val   = RED_LOAD;
    tmr_en    = enable;
    fl_load   = 1'b0;
    fl_en     = 1'b0;

    if (fault) begin
      state_nxt = PH_FLASH;
      ped_nxt   = 1'b0;
      walk_nxt  = 1'b0;
      tmr_en    = 1'b0;
      if (state != PH_FLASH) begin
        fl_load   = 1'b1;
        flash_nxt = 1'b1;
      end else begin
        fl_en = 1'b1;
        if (fl_done) begin
          flash_nxt = !flash_on;
          fl_load   = 1'b1;
        end
      end
    end else if (state == PH_FLASH) begin
      state_nxt = PH_RED;
      tmr_load  = 1'b1;
      tmr_val   = RED_LOAD;
      tmr_en    = 1'b0;
      walk_nxt  = 1'b0;
      ped_nxt   = 1'b0;
      flash_nxt = 1'b0;
    end else if (enable) begin
      unique case (state)
        PH_RED: begin
          if (tmr_done) begin
            state_nxt = PH_GREEN;
            tmr_load  = 1'b1;
            tmr_val   = GREEN_LOAD;
            walk_nxt  = 1'b0;
          end
        end
        PH_GREEN: begin
          if (tmr_done || (ped_pending && (count <= GREEN_EXIT))) begin
            state_nxt = PH_YELLOW;
            tmr_load  = 1'b1;
            tmr_val   = YELLOW_LOAD;
          end
        end
        PH_YELLOW: begin
          // A request arriving on the RED entry edge is served by this RED.
          if (tmr_done) begin
            state_nxt = PH_RED;
            tmr_load  = 1'b1;
            tmr_val   = RED_LOAD;
            walk_nxt  = ped_pending | ped_req;
            ped_nxt   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= PH_RED;
      ped_pending <= 1'b0;
      walk        <= 1'b0;
      flash_on    <= 1'b0;
      RED         <= 1'b1;
      GREEN       <= 1'b0;
      YELLOW      <= 1'b0;
    end else begin
      state       <= state_nxt;
      ped_pending <= ped_nxt;
      walk        <= walk_nxt;
      flash_on    <= flash_nxt;
      RED         <= (state_nxt == PH_RED);
      GREEN       <= (state_nxt == PH_GREEN);
      YELLOW      <= (state_nxt == PH_YELLOW) || ((state_nxt == PH_FLASH) && flash_nxt);
    end
  end

  assign phase = state;

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

- Generates the one-hot RED/GREEN/YELLOW light sequence for a single approach.
- It is the design whose outputs the traffic assertion checker and UVM monitor observe; it sits between the bench stimulus (enable, pedestrian request, fault) and the light outputs.
- Fixed-duration phases, with optional early green termination on pedestrian request, a walk indication and a fault flash mode.

## Interface
Parameters:
- RED_CYCLES, 10, cycles RED is held per phase (>=1)
- GREEN_CYCLES, 15, cycles GREEN is held per phase (>=1)
- YELLOW_CYCLES, 5, cycles YELLOW is held per phase (>=1)
- GREEN_MIN_CYCLES, 5, minimum GREEN cycles before pedestrian early exit (1..GREEN_CYCLES)
- FLASH_HALF_CYCLES, 4, YELLOW on/off half-period in fault mode (>=1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = timer runs; 0 = freeze state and count
- ped_req  in  1  pedestrian request, level or pulse, sampled each cycle
- fault  in  1  1 = enter/stay in flash mode
- RED  out  1  red light
- GREEN  out  1  green light
- YELLOW  out  1  yellow light
- walk  out  1  pedestrian walk indication
- phase  out  2  current state: 0 RED, 1 GREEN, 2 YELLOW, 3 FLASH

## Operation
- States: S_RED, S_GREEN, S_YELLOW, S_FLASH. Normal cycle is RED -> GREEN -> YELLOW -> RED.
- Lights are registered and decoded from state. At most one of RED/GREEN/YELLOW is 1 in any cycle.
- Phase timer: a down-counter loaded with DURATION-1 on phase entry. It decrements when enable=1. At count 0 with enable=1 the FSM advances next cycle. Each light is therefore high for exactly DURATION enabled cycles.
- enable=0: state, count, lights and walk hold. fault overrides enable.
- Pedestrian request:
  - ped_pending is set whenever ped_req=1.
  - In S_GREEN with ped_pending=1, once GREEN has been high for >= GREEN_MIN_CYCLES enabled cycles, the FSM goes to S_YELLOW next cycle.
  - On entry to S_RED: walk <= ped_pending, and ped_pending clears.
  - walk stays constant for the whole RED phase and is 0 in every other state.
  - A ped_req arriving during RED remains pending and is served at the next RED.
  - ped_req and RED entry in the same cycle: the request is consumed by that entry.
- Fault:
  - fault=1 in any state -> S_FLASH next cycle. RED=GREEN=walk=0; ped_pending clears.
  - In S_FLASH, YELLOW starts at 1 and toggles every FLASH_HALF_CYCLES, regardless of enable.
  - fault=0 in S_FLASH -> S_RED next cycle with a full RED_CYCLES count and walk=0.
- Counter width: $clog2(max duration) bits, minimum 1. No wrap-around: the counter always reloads before reaching an underflow.

## Timing
- Reset asserted (async): state S_RED, RED=1, GREEN=0, YELLOW=0, walk=0, phase=0, count=RED_CYCLES-1, ped_pending=0.
- First cycle after reset release is RED cycle 1.
- Reset mid-phase or mid-flash returns to the reset values immediately; the next sequence starts with a full RED.
- Output latency: 1 cycle from the deciding input/count edge to the light change.
- Pedestrian early exit at the minimum: GREEN is high for exactly GREEN_MIN_CYCLES cycles.
- Phase boundary and fault in the same cycle: fault wins.

## Structure
- Shared package traffic_pkg holds:
  - phase_e enum (PH_RED=0, PH_GREEN=1, PH_YELLOW=2, PH_FLASH=3)
  - default duration constants
  - a max_dur() function for sizing the counter
- Sub-module phase_timer: a loadable down-counter with enable, load value, count and done (count==0 && en) outputs. It is reused for the flash half-period.
- The FSM, ped_pending/walk registers and output decode stay in the top module.

## Test plan
- Reset release with enable=1 and no requests -> RED 10, GREEN 15, YELLOW 5 cycles; repeats with period 30. Mutual-exclusion assertions pass.
- ped_req pulse at GREEN cycle 2 -> YELLOW starts after GREEN cycle 5; following RED has walk=1 for all 10 cycles; the next RED has walk=0.
- enable=0 for 7 cycles at GREEN cycle 8 -> GREEN is held for 22 total cycles and count is frozen; the sequence is otherwise unchanged.
- fault=1 mid-YELLOW -> next cycle phase=3, RED=GREEN=0, YELLOW toggles every 4 cycles. Clearing fault -> full 10-cycle RED with walk=0. Timing checks are disabled while phase=3.
- reset asserted at GREEN cycle 9 -> RED=1 immediately; after release, a full RED (10 cycles) precedes GREEN.
- ped_req held during an entire RED phase -> walk=0 for that RED; walk=1 on the next RED after an early green exit at GREEN_MIN.
